output_argmax: RTL and testbench

OUTPUT_ARGMAX -- requirements
Module: output_argmax

---
 rtl/output_argmax_if.sv | 38 +++
 rtl/output_argmax.sv | 144 ++++++++++++++
 tb/tb_output_argmax.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/output_argmax_if.sv
// ---------------------------------------------------------------------------
// output_argmax_if
// Bundles the streaming input and result handshakes of output_argmax.
//
// Signals:
//   in_data     signed 8-bit activation, driven by the producer
//   in_valid    in_data is valid this cycle
//   in_ready    argmax block can take in_data this cycle
//   class_idx   index of the winning activation
//   class_score value of the winning activation
//   out_valid   class_idx/class_score hold a completed frame result
//   out_ready   downstream accepts the result this cycle
//
// Modports:
//   master  producer/consumer side (testbench or surrounding system)
//   slave   the argmax block itself
// ---------------------------------------------------------------------------
interface output_argmax_if #(
  parameter int IDX_W = 4
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] class_idx;
  logic [7:0]       class_score;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, class_idx, class_score, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, class_idx, class_score, out_valid
  );
endinterface

// File: rtl/output_argmax.sv
// ---------------------------------------------------------------------------
// output_argmax
// Takes a frame of NUM_CLASSES signed 8-bit activations, one per accepted
// beat, and reports the index and value of the largest one. The result is
// held until downstream takes it, then a new frame can start.
//
// Parameters:
//   NUM_CLASSES  activations per frame (2 .. 2**IDX_W)
//   IDX_W        width of the class index
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high reset
//   bus    output_argmax_if.slave (in_data/in_valid/in_ready,
//          class_idx/class_score/out_valid/out_ready)
//
// Build option:
//   ARGMAX_TIE_LAST_EN  when defined, ties select the latest index;
//                       when undefined, the earliest index wins.
// ---------------------------------------------------------------------------
module output_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  output_argmax_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic {
    ST_ACCUM,
    ST_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              w_inReady;
  logic              w_outValid;

  logic [IDX_W-1:0]  r_cnt;
  logic signed [7:0] r_runMax;
  logic [IDX_W-1:0]  r_runIdx;
  logic [IDX_W-1:0]  r_classIdx;
  logic signed [7:0] r_classScore;

  logic signed [7:0] w_inData;
  logic              w_beat;
  logic              w_lastBeat;
  logic              w_takeNew;
  logic signed [7:0] w_newMax;
  logic [IDX_W-1:0]  w_newIdx;

  assign w_inData   = signed'(bus.in_data);
  assign w_beat     = bus.in_valid && w_inReady;
  assign w_lastBeat = w_beat && (r_cnt == LAST_IDX);

  // Whether the incoming activation replaces the running winner; the tie
  // policy is selected at build time.
`ifdef ARGMAX_TIE_LAST_EN
  assign w_takeNew = (w_inData >= r_runMax);
`else
  assign w_takeNew = (w_inData > r_runMax);
`endif

  // Post-compare winner for the current beat. The first beat of a frame
  // always seeds the running state so nothing leaks from the previous frame.
  always_comb begin
    w_newMax = r_runMax;
    w_newIdx = r_runIdx;
    if (r_cnt == '0) begin
      w_newMax = w_inData;
      w_newIdx = '0;
    end else if (w_takeNew) begin
      w_newMax = w_inData;
      w_newIdx = r_cnt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. ACCUM takes beats until the last one
  // of the frame; HOLD presents the result until out_ready, which gives the
  // mandatory one-cycle bubble between frames.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_inReady = 1'b1;
        if (w_lastBeat) begin
          w_nextState = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_nextState = ST_ACCUM;
        end
      end
      default: begin
        w_nextState = ST_ACCUM;
      end
    endcase
  end

  // Frame datapath: element counter, running winner and the published
  // result, which only changes on the last beat of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_runMax     <= '0;
      r_runIdx     <= '0;
      r_classIdx   <= '0;
      r_classScore <= '0;
    end else if (w_beat) begin
      r_runMax <= w_newMax;
      r_runIdx <= w_newIdx;
      if (w_lastBeat) begin
        r_cnt        <= '0;
        r_classIdx   <= w_newIdx;
        r_classScore <= w_newMax;
      end else begin
        r_cnt <= r_cnt + ONE_IDX;
      end
    end
  end

  assign bus.in_ready    = w_inReady;
  assign bus.out_valid   = w_outValid;
  assign bus.class_idx   = r_classIdx;
  assign bus.class_score = r_classScore;

endmodule

// File: tb/tb_output_argmax.sv
// ---------------------------------------------------------------------------
// tb_output_argmax
// Directed and randomized frames for output_argmax with a reference model
// that finds the frame maximum and then picks the first (or, with
// ARGMAX_TIE_LAST_EN, the last) position holding it.
// ---------------------------------------------------------------------------
module tb_output_argmax;

  localparam int NC    = 10;
  localparam int IDX_W = 4;

  logic clk;
  logic reset;

  output_argmax_if #(.IDX_W(IDX_W)) bus ();

  output_argmax #(
    .NUM_CLASSES (NC),
    .IDX_W       (IDX_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int frameVals[NC];
  int expIdx;
  int expScore;
  int heldIdx;
  int heldScore;

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag,
                             input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Reference: maximum value first, then the first or last position holding it.
  task automatic refModel();
    int mx;
    mx = frameVals[0];
    for (int i = 1; i < NC; i++) if (frameVals[i] > mx) mx = frameVals[i];
    expScore = mx;
    expIdx   = -1;
    for (int i = 0; i < NC; i++) begin
      if (frameVals[i] == mx) begin
`ifdef ARGMAX_TIE_LAST_EN
        expIdx = i;
`else
        if (expIdx < 0) expIdx = i;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed frameVals as one frame, optionally with random idle gaps, then
  // check the result appears one cycle after the last beat.
  task automatic applyStimulus(input bit gaps);
    for (int i = 0; i < NC; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) tick();
        checkOutput("gap_in_ready", bus.in_ready, 1);
        checkOutput("gap_out_valid", bus.out_valid, 0);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(frameVals[i]);
      tick();
      if (i == NC - 2) checkOutput("pre_last_out_valid", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;
    refModel();
    checkOutput("result_out_valid", bus.out_valid, 1);
    checkOutput("result_in_ready", bus.in_ready, 0);
    checkOutput("result_idx", bus.class_idx, expIdx);
    checkOutput("result_score", $signed(bus.class_score), expScore);
  endtask

  // Accept the pending result and check the bubble/return to ACCUM while
  // the published result stays put.
  task automatic releaseResult();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("release_out_valid", bus.out_valid, 0);
    checkOutput("release_in_ready", bus.in_ready, 1);
    checkOutput("release_idx_kept", bus.class_idx, expIdx);
    checkOutput("release_score_kept", $signed(bus.class_score), expScore);
  endtask

  task automatic setFrame(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    frameVals = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_idx", bus.class_idx, 0);
    checkOutput("reset_score", $signed(bus.class_score), 0);

    // Mixed values with extremes.
    setFrame(3, -5, 17, 2, 9, 17, 0, -128, 127, 1);
    applyStimulus(1'b0);
    releaseResult();

    // Tie at the top.
    setFrame(5, 5, -1, -1, -1, -1, -1, -1, -1, -1);
    applyStimulus(1'b0);
    releaseResult();

    // All most-negative: signed compare and full-frame tie.
    for (int i = 0; i < NC; i++) frameVals[i] = -128;
    applyStimulus(1'b0);

    // Hold result under backpressure with in_valid asserted.
    heldIdx   = expIdx;
    heldScore = expScore;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.in_data = 8'($urandom);
      tick();
      checkOutput("hold_in_ready", bus.in_ready, 0);
      checkOutput("hold_out_valid", bus.out_valid, 1);
      checkOutput("hold_idx", bus.class_idx, heldIdx);
      checkOutput("hold_score", $signed(bus.class_score), heldScore);
    end
    bus.in_valid = 1'b0;
    releaseResult();

    // Next frame must start at index 0: winner at position 0.
    setFrame(50, 1, 2, 3, 4, 5, 6, 7, 8, 49);
    applyStimulus(1'b0);
    releaseResult();

    // Partial frame discarded by reset, then ascending frame.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'd100;
      tick();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_idx", bus.class_idx, 0);
    checkOutput("midreset_in_ready", bus.in_ready, 1);
    for (int i = 0; i < NC; i++) frameVals[i] = i;
    applyStimulus(1'b0);
    releaseResult();
    applyStimulus(1'b1);

    // Reset while a result is pending.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("holdreset_out_valid", bus.out_valid, 0);
    checkOutput("holdreset_in_ready", bus.in_ready, 1);
    checkOutput("holdreset_score", $signed(bus.class_score), 0);

    // Randomized frames with a narrow value range to provoke ties.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NC; i++) begin
        if (f < 4) frameVals[i] = int'($urandom_range(0, 7)) - 4;
        else       frameVals[i] = int'($urandom_range(0, 255)) - 128;
      end
      applyStimulus(f[0]);
      releaseResult();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
